// File: rtl/decode_led_seq_pkg.sv
// -----------------------------------------------------------------------------
// decode_led_pkg
// Shared definitions for the decode_led_seq block:
//   - 2-bit mode encodings
//   - bounce direction state type (also exported on the debug bus)
//   - onehot()/therm() pattern helpers, parametrised by output width
// -----------------------------------------------------------------------------
package decode_led_pkg;

    localparam logic [1:0] MODE_ONEHOT = 2'b00;
    localparam logic [1:0] MODE_THERM  = 2'b01;
    localparam logic [1:0] MODE_SCAN   = 2'b10;
    localparam logic [1:0] MODE_BOUNCE = 2'b11;

    // Widest pattern the helpers can build; callers size-cast the result.
    localparam int unsigned MAX_OUT_W = 64;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // Bit idx set, all others clear; bits at or above width are forced to 0.
    function automatic logic [MAX_OUT_W-1:0] onehot(input int unsigned idx,
                                                    input int unsigned width);
        logic [MAX_OUT_W-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < MAX_OUT_W; i++) begin
            v[i] = (i == idx) && (i < width);
        end
        return v;
    endfunction

    // Bits 0..idx set; bits at or above width are forced to 0.
    function automatic logic [MAX_OUT_W-1:0] therm(input int unsigned idx,
                                                   input int unsigned width);
        logic [MAX_OUT_W-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < MAX_OUT_W; i++) begin
            v[i] = (i <= idx) && (i < width);
        end
        return v;
    endfunction

endpackage

// File: rtl/decode_led_seq_if.sv
// -----------------------------------------------------------------------------
// decode_led_seq_if
// Control/LED bus of decode_led_seq.
//   en, mode, a      : driven by the controller (master) into the decoder
//   led, tick        : registered decoder outputs
//   dbg_idx, dbg_dir : sequencer state (current index and bounce direction)
// Inputs are level-sampled on every rising clk; there is no valid/ready
// handshake on this bus, the decoder consumes whatever is presented each cycle.
// -----------------------------------------------------------------------------
interface decode_led_seq_if #(
    parameter int SEL_W = 2
) ();
    localparam int OUT_W = 2 ** SEL_W;

    logic                       en;
    logic [1:0]                 mode;
    logic [SEL_W-1:0]           a;
    logic [OUT_W-1:0]           led;
    logic                       tick;
    logic [SEL_W-1:0]           dbg_idx;
    decode_led_pkg::dir_e       dbg_dir;

    modport master (
        output en, mode, a,
        input  led, tick, dbg_idx, dbg_dir
    );

    modport slave (
        input  en, mode, a,
        output led, tick, dbg_idx, dbg_dir
    );
endinterface

// File: rtl/decode_led_seq_tick_div.sv
// -----------------------------------------------------------------------------
// tick_div
// Free-running step divider. While run=1 the counter walks 0..DIV-1 and
// tick pulses for one cycle each time it wraps; run=0 clears the counter, so
// dropping run for one cycle restarts a full period.
// Ports:
//   clk   : clock
//   rst_n : synchronous active-low reset
//   run   : count enable (low = counter held at 0)
//   tick  : registered one-cycle pulse per DIV counted cycles
// -----------------------------------------------------------------------------
module tick_div #(
    parameter int DIV = 12_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic tick
);
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_tick;
    logic             w_wrap;

    assign w_wrap = (r_cnt == LAST);
    assign tick   = r_tick;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            if (!run || w_wrap) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            r_tick <= run && w_wrap;
        end
    end
endmodule

// File: rtl/decode_led_seq.sv
// -----------------------------------------------------------------------------
// decode_led_seq
// Registered SEL_W -> 2**SEL_W LED decoder with one-hot, thermometer,
// running-light (scan) and ping-pong (bounce) modes.
// Ports:
//   clk   : system clock
//   rst_n : synchronous active-low reset
//   bus   : decode_led_seq_if.slave (en, mode, a in; led, tick, debug out)
// -----------------------------------------------------------------------------
module decode_led_seq
    import decode_led_pkg::*;
#(
    parameter int SEL_W      = 2,
    parameter int SCAN_DIV   = 12_000_000,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    decode_led_seq_if.slave        bus
);
    localparam int OUT_W = 2 ** SEL_W;
    localparam logic [SEL_W-1:0] IDX_MAX  = SEL_W'(OUT_W - 1);
    localparam logic [OUT_W-1:0] LED_IDLE = ACTIVE_LOW ? {OUT_W{1'b1}} : '0;

    logic [SEL_W-1:0] r_idx;
    dir_e             r_dir;
    logic [1:0]       r_mode;
    logic             r_en;
    logic [OUT_W-1:0] r_led;

    logic             w_is_seq;
    logic             w_entry;
    logic             w_run;
    logic             w_tick;
    logic [SEL_W-1:0] w_idx_nxt;
    dir_e             w_dir_nxt;
    logic [OUT_W-1:0] w_pat;

    // Entry = first enabled cycle in a sequencing mode, or a switch between
    // scan and bounce. The divider is held in reset that cycle so the first
    // step comes a full period after the reload, and any tick already in
    // flight is ignored because the reload takes priority below.
    always_comb begin
        w_is_seq = (bus.mode == MODE_SCAN) || (bus.mode == MODE_BOUNCE);
        w_entry  = bus.en && w_is_seq && (!r_en || (r_mode != bus.mode));
        w_run    = bus.en && w_is_seq && !w_entry;
    end

    tick_div #(
        .DIV (SCAN_DIV)
    ) u_tick_div (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (w_run),
        .tick  (w_tick)
    );

    // Next sequencer position. Bounce flips direction on the step that lands
    // on an end, so each end LED is shown for exactly one step.
    always_comb begin
        w_idx_nxt = r_idx;
        w_dir_nxt = r_dir;
        if (w_entry) begin
            w_idx_nxt = bus.a;
            w_dir_nxt = ((bus.mode == MODE_BOUNCE) && (bus.a == IDX_MAX)) ? DIR_DOWN : DIR_UP;
        end else if (w_run && w_tick) begin
            if (bus.mode == MODE_SCAN) begin
                w_idx_nxt = r_idx + 1'b1;   // natural wrap OUT_W-1 -> 0
            end else if (r_dir == DIR_UP) begin
                w_idx_nxt = r_idx + 1'b1;
                if (w_idx_nxt == IDX_MAX) w_dir_nxt = DIR_DOWN;
            end else begin
                w_idx_nxt = r_idx - 1'b1;
                if (w_idx_nxt == '0) w_dir_nxt = DIR_UP;
            end
        end
    end

    // Active-high pattern; polarity is applied only when it is registered.
    always_comb begin
        w_pat = '0;
        if (bus.en) begin
            case (bus.mode)
                MODE_ONEHOT: w_pat = OUT_W'(onehot(int'(bus.a), OUT_W));
                MODE_THERM:  w_pat = OUT_W'(therm(int'(bus.a), OUT_W));
                default:     w_pat = OUT_W'(onehot(int'(w_idx_nxt), OUT_W));
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx  <= '0;
            r_dir  <= DIR_UP;
            r_mode <= MODE_ONEHOT;
            r_en   <= 1'b0;
            r_led  <= LED_IDLE;
        end else begin
            r_mode <= bus.mode;
            r_en   <= bus.en;
            r_led  <= ACTIVE_LOW ? ~w_pat : w_pat;
            // Position is frozen while disabled; a later enable reloads it.
            if (bus.en) begin
                r_idx <= w_idx_nxt;
                r_dir <= w_dir_nxt;
            end
        end
    end

    assign bus.led     = r_led;
    assign bus.tick    = w_tick;
    assign bus.dbg_idx = r_idx;
    assign bus.dbg_dir = r_dir;
endmodule

// File: tb/tb_decode_led_seq.sv
module tb_decode_led_seq;
    import decode_led_pkg::*;

    logic clk;
    logic rst_n;
    logic rst_c_n;
    int   n_checks;
    int   n_fail;

    // A: SCAN_DIV=4 active-high; B: SCAN_DIV=1 active-high; C: SCAN_DIV=4 active-low
    decode_led_seq_if #(.SEL_W(2)) bus_a ();
    decode_led_seq_if #(.SEL_W(2)) bus_b ();
    decode_led_seq_if #(.SEL_W(2)) bus_c ();

    decode_led_seq #(.SEL_W(2), .SCAN_DIV(4), .ACTIVE_LOW(1'b0)) u_dut_a (
        .clk (clk), .rst_n (rst_n), .bus (bus_a.slave));
    decode_led_seq #(.SEL_W(2), .SCAN_DIV(1), .ACTIVE_LOW(1'b0)) u_dut_b (
        .clk (clk), .rst_n (rst_n), .bus (bus_b.slave));
    decode_led_seq #(.SEL_W(2), .SCAN_DIV(4), .ACTIVE_LOW(1'b1)) u_dut_c (
        .clk (clk), .rst_n (rst_c_n), .bus (bus_c.slave));

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance one clock; inputs are driven and outputs sampled 1 ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rst_c_n = 1'b0;
        bus_a.en = 1'b0; bus_a.mode = MODE_ONEHOT; bus_a.a = 2'd0;
        bus_b.en = 1'b0; bus_b.mode = MODE_ONEHOT; bus_b.a = 2'd0;
        bus_c.en = 1'b0; bus_c.mode = MODE_ONEHOT; bus_c.a = 2'd0;
        step();
        step();
        n_checks++; if (bus_a.led !== 4'b0000) begin n_fail++; $display("FAIL reset_led_a: got %b want 0000", bus_a.led); end
        n_checks++; if (bus_a.tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick_a: got %b want 0", bus_a.tick); end
        n_checks++; if (bus_a.dbg_idx !== 2'd0) begin n_fail++; $display("FAIL reset_idx_a: got %0d want 0", bus_a.dbg_idx); end
        n_checks++; if (bus_b.led !== 4'b0000) begin n_fail++; $display("FAIL reset_led_b: got %b want 0000", bus_b.led); end
        n_checks++; if (bus_c.led !== 4'b1111) begin n_fail++; $display("FAIL reset_led_c_activelow: got %b want 1111", bus_c.led); end
        n_checks++; if (bus_c.dbg_dir !== DIR_UP) begin n_fail++; $display("FAIL reset_dir_c: got %b want up", bus_c.dbg_dir); end
    endtask

    task automatic test_onehot();
        rst_n = 1'b1;
        bus_a.en = 1'b1; bus_a.mode = MODE_ONEHOT; bus_a.a = 2'd2;
        step();
        n_checks++; if (bus_a.led !== 4'b0100) begin n_fail++; $display("FAIL onehot_a2: got %b want 0100", bus_a.led); end
        bus_a.a = 2'd3;
        step();
        n_checks++; if (bus_a.led !== 4'b1000) begin n_fail++; $display("FAIL onehot_a3: got %b want 1000", bus_a.led); end
        bus_a.a = 2'd0;
        step();
        n_checks++; if (bus_a.led !== 4'b0001) begin n_fail++; $display("FAIL onehot_a0: got %b want 0001", bus_a.led); end
        n_checks++; if (bus_a.tick !== 1'b0) begin n_fail++; $display("FAIL onehot_no_tick: got %b want 0", bus_a.tick); end
    endtask

    task automatic test_therm();
        logic [3:0] exp_t [4];
        exp_t = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};
        bus_a.mode = MODE_THERM;
        for (int i = 0; i < 4; i++) begin
            bus_a.a = 2'(i);
            step();
            n_checks++;
            if (bus_a.led !== exp_t[i]) begin
                n_fail++; $display("FAIL therm_a%0d: got %b want %b", i, bus_a.led, exp_t[i]);
            end
        end
    endtask

    task automatic test_scan();
        logic [3:0] exp_s [4];
        logic       exp_tick;
        exp_s = '{4'b0100, 4'b1000, 4'b0001, 4'b0010};
        bus_a.mode = MODE_SCAN; bus_a.a = 2'd2;
        step();
        n_checks++; if (bus_a.led !== 4'b0100) begin n_fail++; $display("FAIL scan_entry_led: got %b want 0100", bus_a.led); end
        n_checks++; if (bus_a.dbg_idx !== 2'd2) begin n_fail++; $display("FAIL scan_entry_idx: got %0d want 2", bus_a.dbg_idx); end
        bus_a.a = 2'd0; // ignored after entry
        for (int k = 1; k <= 13; k++) begin
            step();
            exp_tick = ((k % 4) == 0);
            n_checks++;
            if (bus_a.tick !== exp_tick) begin
                n_fail++; $display("FAIL scan_tick_k%0d: got %b want %b", k, bus_a.tick, exp_tick);
            end
            n_checks++;
            if (bus_a.led !== exp_s[(k - 1) / 4]) begin
                n_fail++; $display("FAIL scan_led_k%0d: got %b want %b", k, bus_a.led, exp_s[(k - 1) / 4]);
            end
        end
    endtask

    task automatic test_bounce();
        logic [3:0] exp_l [9];
        dir_e       exp_d [9];
        exp_l = '{4'b1000, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100};
        exp_d = '{DIR_DOWN, DIR_DOWN, DIR_DOWN, DIR_DOWN, DIR_UP, DIR_UP, DIR_UP, DIR_DOWN, DIR_DOWN};
        bus_b.en = 1'b1; bus_b.mode = MODE_BOUNCE; bus_b.a = 2'd3;
        for (int k = 0; k < 9; k++) begin
            step();
            n_checks++;
            if (bus_b.led !== exp_l[k]) begin
                n_fail++; $display("FAIL bounce_led_k%0d: got %b want %b", k, bus_b.led, exp_l[k]);
            end
            n_checks++;
            if (bus_b.dbg_dir !== exp_d[k]) begin
                n_fail++; $display("FAIL bounce_dir_k%0d: got %b want %b", k, bus_b.dbg_dir, exp_d[k]);
            end
        end
        n_checks++; if (bus_b.tick !== 1'b1) begin n_fail++; $display("FAIL bounce_tick_div1: got %b want 1", bus_b.tick); end
    endtask

    // bounce -> scan switch while a tick is pending: reload wins, tick discarded
    task automatic test_back_to_back();
        bus_b.mode = MODE_SCAN; bus_b.a = 2'd1;
        step();
        n_checks++; if (bus_b.led !== 4'b0010) begin n_fail++; $display("FAIL switch_entry_led: got %b want 0010", bus_b.led); end
        n_checks++; if (bus_b.tick !== 1'b0) begin n_fail++; $display("FAIL switch_entry_tick: got %b want 0", bus_b.tick); end
        step();
        n_checks++; if (bus_b.led !== 4'b0010) begin n_fail++; $display("FAIL switch_hold_led: got %b want 0010", bus_b.led); end
        n_checks++; if (bus_b.tick !== 1'b1) begin n_fail++; $display("FAIL switch_first_tick: got %b want 1", bus_b.tick); end
        step();
        n_checks++; if (bus_b.led !== 4'b0100) begin n_fail++; $display("FAIL switch_step_led: got %b want 0100", bus_b.led); end
    endtask

    task automatic test_enable_polarity();
        rst_c_n = 1'b1;
        bus_c.en = 1'b1; bus_c.mode = MODE_SCAN; bus_c.a = 2'd0;
        step();
        n_checks++; if (bus_c.led !== 4'b1110) begin n_fail++; $display("FAIL al_entry_led: got %b want 1110", bus_c.led); end
        for (int k = 1; k <= 9; k++) begin
            step();
            if (k == 4 || k == 8) begin
                n_checks++;
                if (bus_c.tick !== 1'b1) begin n_fail++; $display("FAIL al_tick_k%0d: got %b want 1", k, bus_c.tick); end
            end
        end
        n_checks++; if (bus_c.led !== 4'b1011) begin n_fail++; $display("FAIL al_scan_led: got %b want 1011", bus_c.led); end
        n_checks++; if (bus_c.dbg_idx !== 2'd2) begin n_fail++; $display("FAIL al_scan_idx: got %0d want 2", bus_c.dbg_idx); end
        bus_c.en = 1'b0;
        step();
        n_checks++; if (bus_c.led !== 4'b1111) begin n_fail++; $display("FAIL al_disable_led: got %b want 1111", bus_c.led); end
        bus_c.a = 2'd3;
        repeat (3) step();
        n_checks++; if (bus_c.dbg_idx !== 2'd2) begin n_fail++; $display("FAIL al_frozen_idx: got %0d want 2", bus_c.dbg_idx); end
        n_checks++; if (bus_c.led !== 4'b1111) begin n_fail++; $display("FAIL al_frozen_led: got %b want 1111", bus_c.led); end
        n_checks++; if (bus_c.tick !== 1'b0) begin n_fail++; $display("FAIL al_frozen_tick: got %b want 0", bus_c.tick); end
        bus_c.en = 1'b1; bus_c.a = 2'd1;
        step();
        n_checks++; if (bus_c.led !== 4'b1101) begin n_fail++; $display("FAIL al_reenable_led: got %b want 1101", bus_c.led); end
        n_checks++; if (bus_c.dbg_idx !== 2'd1) begin n_fail++; $display("FAIL al_reenable_idx: got %0d want 1", bus_c.dbg_idx); end
        repeat (3) step();
        n_checks++; if (bus_c.tick !== 1'b0) begin n_fail++; $display("FAIL al_pre_tick: got %b want 0", bus_c.tick); end
        // divider is at its last count: reset lands on the edge that would tick
        rst_c_n = 1'b0;
        step();
        n_checks++; if (bus_c.led !== 4'b1111) begin n_fail++; $display("FAIL al_midreset_led: got %b want 1111", bus_c.led); end
        n_checks++; if (bus_c.tick !== 1'b0) begin n_fail++; $display("FAIL al_midreset_tick: got %b want 0", bus_c.tick); end
        n_checks++; if (bus_c.dbg_idx !== 2'd0) begin n_fail++; $display("FAIL al_midreset_idx: got %0d want 0", bus_c.dbg_idx); end
        rst_c_n = 1'b1; bus_c.a = 2'd3;
        step();
        n_checks++; if (bus_c.led !== 4'b0111) begin n_fail++; $display("FAIL al_post_reset_led: got %b want 0111", bus_c.led); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_onehot();
        test_therm();
        test_scan();
        test_bounce();
        test_back_to_back();
        test_enable_polarity();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/decode_led_seq.md
Name: decode_led_seq

Overview:
- Parametrised, registered successor to the board's 2-4 LED decoder.
- Decodes an SEL_W-bit index onto OUT_W = 2^SEL_W LEDs in one of four modes:
  - one-hot
  - thermometer
  - auto-scan (running light)
  - bounce (ping-pong light)
- Scan and bounce advance on an internal tick divider, so the block drives board LEDs directly from the 12 MHz system clock.

Parameters:
- SEL_W, 2, index width; OUT_W = 2**SEL_W derived (localparam).
- SCAN_DIV, 12_000_000, clock cycles per scan step (1 s at 12 MHz); legal range >= 1.
- ACTIVE_LOW, 0, 1 inverts every led bit at the output register (STEP LEDs are active-low).

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, synchronous active-low reset.
- en, input, 1, block enable.
- mode, input, 2, 00 one-hot, 01 thermometer, 10 scan, 11 bounce.
- a, input, SEL_W, decode index / scan start position.
- led, output, OUT_W, registered LED pattern.
- tick, output, 1, one-cycle pulse on each scan step (debug/chaining).

Behaviour:
- Reset:
  - Synchronous, sampled on rising clk while rst_n=0.
  - idx=0, dir=up, divider=0, tick=0.
  - led = all-inactive: 0s, or all 1s if ACTIVE_LOW.
  - Reset asserted mid-scan overrides everything in that cycle.
- Divider:
  - Counts 0..SCAN_DIV-1 while en=1 and mode is 10 or 11.
  - tick=1 in the cycle the count wraps.
  - Counter is held at 0 in other modes or when en=0.
  - SCAN_DIV=1 gives tick every cycle.
  - Counter width is $clog2(SCAN_DIV) with a minimum of 1.
- Mode 00:
  - led <= one-hot(a): bit a set, all others clear.
  - Latency 1 clk from a change.
- Mode 01:
  - led <= thermometer(a): bits 0..a set.
  - a=0 lights bit 0 only; a=OUT_W-1 lights all.
  - Latency 1.
- Mode 10 (scan):
  - On the cycle mode changes into 10 (previous registered mode != 10), or en rises while mode=10: idx <= a, led shows one-hot(a) next cycle.
  - Thereafter, on each tick: idx <= idx+1, wrapping OUT_W-1 -> 0.
  - led = one-hot(idx), updated the cycle after idx changes.
- Mode 11 (bounce):
  - Entry loads idx <= a.
  - Entry direction: dir=up, except dir=down when a=OUT_W-1.
  - On tick, moving up: idx+1; when idx reaches OUT_W-1, dir flips to down.
  - On tick, moving down: idx-1; when idx reaches 0, dir flips to up.
  - End LEDs are shown for exactly one step each (sequence 0,1,2,3,2,1,0,1…).
- en=0:
  - led all-inactive next cycle.
  - idx, dir and divider held.
  - Re-enable in scan/bounce reloads from a (entry rule).
- Mode change between 10 and 11: treated as an entry; idx reloads from a; divider restarts at 0.
- Simultaneous tick and entry: the entry wins and the tick is discarded.
- Changes to a during scan/bounce after entry are ignored.
- ACTIVE_LOW inversion is applied only at the output register; tick is never inverted.
- Out-of-range idx cannot occur, since width is exactly SEL_W.

Decomposition:
- Package decode_led_pkg:
  - Mode encoding constants MODE_ONEHOT, MODE_THERM, MODE_SCAN, MODE_BOUNCE (2-bit).
  - Functions onehot(idx) and therm(idx), parametrised by width.
- Sub-module tick_div (parameter DIV; ports clk, rst_n, run, tick): reusable divider.
- The decoder/sequencer stays in the top module.

Test Plan:
- Reset and one-hot:
  - Stimulus: SEL_W=2, ACTIVE_LOW=0; rst_n=0 for 2 clk, then en=1, mode=00, a=2.
  - Required: led=0000 during reset; led=0100 one clk after release; a=3 gives 1000 next clk.
- Thermometer:
  - Stimulus: mode=01, a=0,1,2,3 in successive cycles.
  - Required: led=0001, 0011, 0111, 1111, each with latency 1.
- Scan wrap:
  - Stimulus: SCAN_DIV=4, mode=10 entered with a=2.
  - Required: led=0100, then 1000, 0001, 0010 at successive ticks; tick pulses every 4 clk.
- Bounce with direction reversal:
  - Stimulus: SCAN_DIV=1, mode=11, a=3.
  - Required: led=1000, 0100, 0010, 0001, 0010, 0100, 1000; dir starts down.
- Enable, polarity and reset mid-scan:
  - Stimulus: ACTIVE_LOW=1 mid-scan.
  - Required: en=0 gives led=1111 and idx frozen; en=1 with a=1 gives led=1101.
  - Required: rst_n=0 pulse while tick is due gives led=1111 and tick=0.
